debouncer: RTL

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debounce_pkg.sv | 12 +
 rtl/sync_2ff.sv | 25 ++
 rtl/debouncer.sv | 107 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input debouncer.
// Holds the FSM state encoding and the default qualification length.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing the raw level into the clk domain.
// The output lags the input by two rising edges.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronises d_in, qualifies a level change over a run of samples,
// and emits registered edge pulses plus a wrapping rising-edge counter.
//
// state  | meaning
// STABLE | synchronised input agrees with q_stable, nothing pending
// CHECK  | synchronised input differs, candidate change being qualified
module debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_in,
    output logic       q_stable,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] edge_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_d_s;
    logic             w_differ;
    logic             w_accept;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;
    logic [7:0]       r_edge_cnt;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d_in),
        .q       (w_d_s)
    );

    assign w_differ = (w_d_s != r_q);

    // r_cnt is the number of differing samples already seen; the change is
    // accepted on the sample that completes DEBOUNCE_CYCLES of them.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_accept    = 1'b0;
        case (r_state)
            STABLE: begin
                if (w_differ) begin
                    w_state_nxt = CHECK;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            CHECK: begin
                if (!w_differ) begin
                    w_state_nxt = STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STABLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= STABLE;
            r_cnt      <= '0;
            r_q        <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_busy     <= 1'b0;
            r_edge_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == CHECK);
            r_rise  <= w_accept & ~r_q;
            r_fall  <= w_accept & r_q;
            if (w_accept) begin
                r_q <= ~r_q;
            end
            if (w_accept && !r_q) begin
                r_edge_cnt <= r_edge_cnt + 8'd1;
            end
        end
    end

    assign q_stable   = r_q;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;
    assign edge_count = r_edge_cnt;

endmodule
